// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern link: FSM state codes, the two
// fixed patterns (also used by the 1011/0101 detector) and the sel encodings.
package seq_pattern_tx_pkg;

  // FSM state codes; the remaining 3-bit codes are illegal.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_GAP   = 3'd2,
    ST_DONE  = 3'd3
  } state_e;

  // Fixed patterns shared with the detector so both ends agree.
  localparam logic [3:0] PAT_A = 4'b1011;
  localparam logic [3:0] PAT_B = 4'b0101;

  // Pattern select codes.
  localparam logic [1:0] SEL_PAT_A    = 2'b00;
  localparam logic [1:0] SEL_PAT_B    = 2'b01;
  localparam logic [1:0] SEL_WORD     = 2'b10;
  localparam logic [1:0] SEL_WORD_INV = 2'b11;

  // Map a sel code and custom word onto the 4-bit frame to transmit.
  function automatic logic [3:0] select_pattern(input logic [1:0] sel_i,
                                                input logic [3:0] word_i);
    logic [3:0] pat;
    case (sel_i)
      SEL_PAT_A:    pat = PAT_A;
      SEL_PAT_B:    pat = PAT_B;
      SEL_WORD:     pat = word_i;
      SEL_WORD_INV: pat = ~word_i;
      default:      pat = PAT_A;
    endcase
    return pat;
  endfunction

  // A repeat count of zero still sends one frame.
  function automatic logic [3:0] effective_rep(input logic [3:0] rep_i);
    logic [3:0] n;
    if (rep_i == 4'd0) begin
      n = 4'd1;
    end else begin
      n = rep_i;
    end
    return n;
  endfunction

endpackage

// File: rtl/seq_pattern_shreg.sv
// 4-bit loadable left-shift register. It exposes the MSB the register will
// hold after the coming edge, so the owner can register its own DATA output
// in the same cycle as the shift register itself.
module seq_pattern_shreg
  import seq_pattern_tx_pkg::*;
(
  input  logic       ck,
  input  logic       rs,
  input  logic       load,
  input  logic       shift,
  input  logic [3:0] din,
  output logic       msb_next
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next register value: load has priority over shift, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = din;
    end else if (shift) begin
      q_d = {q_q[2:0], 1'b0};
    end else begin
      q_d = q_q;
    end
  end

  assign msb_next = q_d[3];

  // Shift register storage, cleared by the asynchronous reset.
  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      q_q <= 4'b0000;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: on start, sends the selected 4-bit pattern
// MSB-first, repeated rep times with GAP_CYCLES idle cycles between frames.
// All outputs come straight from flops.
module seq_pattern_tx
  import seq_pattern_tx_pkg::*;
#(
  parameter int   GAP_CYCLES = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic       ck,
  input  logic       rs,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic [3:0] word,
  input  logic [3:0] rep,
  output logic       DATA,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [2:0] c
);

  // Gap counter only needs to reach GAP_CYCLES-1; keep it at least one bit
  // wide so the design still elaborates with GAP_CYCLES = 0.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
  localparam logic [GW-1:0] GAP_LAST = GAP_LAST_I[GW-1:0];
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [GW-1:0] GAP_ZERO = GW'(0);

  state_e        state_q,  state_d;
  logic [3:0]    pat_q,    pat_d;
  logic [3:0]    frames_q, frames_d;
  logic [1:0]    bit_q,    bit_d;
  logic [GW-1:0] gap_q,    gap_d;
  logic          data_q,   data_d;
  logic          valid_q,  valid_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;

  logic          sh_load_s;
  logic          sh_shift_s;
  logic [3:0]    sh_din_s;
  logic          sh_msb_next_s;

  seq_pattern_shreg u_shreg (
    .ck       (ck),
    .rs       (rs),
    .load     (sh_load_s),
    .shift    (sh_shift_s),
    .din      (sh_din_s),
    .msb_next (sh_msb_next_s)
  );

  // Next-state, counter and output decode; outputs default to the idle level.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    frames_d   = frames_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    data_d     = IDLE_LEVEL;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    sh_load_s  = 1'b0;
    sh_shift_s = 1'b0;
    sh_din_s   = pat_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Latch the pattern and repeat count; later input changes are ignored.
          pat_d     = select_pattern(sel, word);
          sh_din_s  = select_pattern(sel, word);
          sh_load_s = 1'b1;
          frames_d  = effective_rep(rep);
          bit_d     = 2'd0;
          gap_d     = GAP_ZERO;
          state_d   = ST_SHIFT;
          data_d    = sh_msb_next_s;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (bit_q == 2'd3) begin
          // Last bit of this frame is on the line now.
          frames_d = frames_q - 4'd1;
          bit_d    = 2'd0;
          if (frames_q == 4'd1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (GAP_CYCLES == 0) begin
            // Back-to-back: reload now so the next MSB follows without a bubble.
            sh_load_s = 1'b1;
            state_d   = ST_SHIFT;
            data_d    = sh_msb_next_s;
            valid_d   = 1'b1;
            busy_d    = 1'b1;
          end else begin
            gap_d   = GAP_ZERO;
            state_d = ST_GAP;
            busy_d  = 1'b1;
          end
        end else begin
          sh_shift_s = 1'b1;
          bit_d      = bit_q + 2'd1;
          state_d    = ST_SHIFT;
          data_d     = sh_msb_next_s;
          valid_d    = 1'b1;
          busy_d     = 1'b1;
        end
      end

      ST_GAP: begin
        busy_d = 1'b1;
        if (gap_q == GAP_LAST) begin
          sh_load_s = 1'b1;
          gap_d     = GAP_ZERO;
          state_d   = ST_SHIFT;
          data_d    = sh_msb_next_s;
          valid_d   = 1'b1;
        end else begin
          gap_d   = gap_q + GAP_ONE;
          state_d = ST_GAP;
        end
      end

      ST_DONE: begin
        // start is deliberately not looked at here.
        state_d = ST_IDLE;
      end

      default: begin
        // Illegal codes fall back to a clean idle.
        state_d  = ST_IDLE;
        frames_d = 4'd0;
        bit_d    = 2'd0;
        gap_d    = GAP_ZERO;
      end
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      state_q  <= ST_IDLE;
      pat_q    <= 4'b0000;
      frames_q <= 4'd0;
      bit_q    <= 2'd0;
      gap_q    <= GAP_ZERO;
      data_q   <= IDLE_LEVEL;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      frames_q <= frames_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign DATA  = data_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign c     = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one instance with a 2-cycle gap and one
// with back-to-back frames, driven by the same stimulus.
module tb_seq_pattern_tx;

  logic       ck;
  logic       rs;
  logic       start;
  logic [1:0] sel;
  logic [3:0] word;
  logic [3:0] rep;

  logic       data_o  [2];
  logic       valid_o [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic [2:0] c_o     [2];

  int total = 0;
  int bad   = 0;

  // Overlapping 1011 hit counter on the back-to-back instance's output.
  logic [2:0] win1  = 3'b000;
  logic [2:0] vwin1 = 3'b000;
  int         hits1 = 0;
  int         hits_base;

  seq_pattern_tx #(.GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) u_g2 (
    .ck(ck), .rs(rs), .start(start), .sel(sel), .word(word), .rep(rep),
    .DATA(data_o[0]), .valid(valid_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .c(c_o[0])
  );

  seq_pattern_tx #(.GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_g0 (
    .ck(ck), .rs(rs), .start(start), .sel(sel), .word(word), .rep(rep),
    .DATA(data_o[1]), .valid(valid_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .c(c_o[1])
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Detector model: count valid 1011 windows on the gap-less instance.
  always @(posedge ck) begin
    win1  <= {win1[1:0], data_o[1]};
    vwin1 <= {vwin1[1:0], valid_o[1]};
    if ({win1, data_o[1]} == 4'b1011 && {vwin1, valid_o[1]} == 4'b1111) begin
      hits1 <= hits1 + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  // Pulse start, then check n busy cycles against the DATA/valid bit strings
  // (MSB = first cycle), the DONE cycle and the return to IDLE.
  task automatic run_frame(input string tag, input int w, input int n,
                           input logic [31:0] d, input logic [31:0] v,
                           input bit perturb, input bit dstart);
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (i == 0) start = 1'b0;
      chk({tag, "_data"},  {7'd0, data_o[w]},  {7'd0, d[n-1-i]});
      chk({tag, "_valid"}, {7'd0, valid_o[w]}, {7'd0, v[n-1-i]});
      chk({tag, "_busy"},  {7'd0, busy_o[w]},  8'd1);
      chk({tag, "_done"},  {7'd0, done_o[w]},  8'd0);
      if (perturb && i == 0) begin
        start = 1'b1;
        sel   = 2'b11;
        word  = 4'b0110;
        rep   = 4'd7;
      end
      if (perturb && i == 2) start = 1'b0;
    end
    step();
    chk({tag, "_done_pulse"}, {7'd0, done_o[w]},  8'd1);
    chk({tag, "_done_busy"},  {7'd0, busy_o[w]},  8'd0);
    chk({tag, "_done_valid"}, {7'd0, valid_o[w]}, 8'd0);
    chk({tag, "_done_data"},  {7'd0, data_o[w]},  8'd0);
    chk({tag, "_done_c"},     {5'd0, c_o[w]},     8'd3);
    if (dstart) begin
      start = 1'b1;
      sel   = 2'b00;
      rep   = 4'd1;
    end
    step();
    chk({tag, "_end_done"}, {7'd0, done_o[w]}, 8'd0);
    chk({tag, "_end_c"},    {5'd0, c_o[w]},    8'd0);
    chk({tag, "_end_busy"}, {7'd0, busy_o[w]}, 8'd0);
  endtask

  initial begin
    rs = 1'b0; start = 1'b0; sel = 2'b00; word = 4'b0000; rep = 4'd0;
    step();
    step();
    for (int w = 0; w < 2; w++) begin
      chk("rst_data",  {7'd0, data_o[w]},  8'd0);
      chk("rst_valid", {7'd0, valid_o[w]}, 8'd0);
      chk("rst_busy",  {7'd0, busy_o[w]},  8'd0);
      chk("rst_done",  {7'd0, done_o[w]},  8'd0);
      chk("rst_c",     {5'd0, c_o[w]},     8'd0);
    end
    rs = 1'b1;
    idle(2);

    // Pattern A, one frame; detector sees exactly one 1011.
    hits_base = hits1;
    sel = 2'b00; rep = 4'd1;
    run_frame("pa1", 0, 4, 32'b1011, 32'b1111, 1'b0, 1'b0);
    idle(2);
    chk("pa1_hits", 8'(hits1 - hits_base), 8'd1);

    // Pattern B, three frames with 2-cycle gaps: 16 busy cycles.
    sel = 2'b01; rep = 4'd3;
    run_frame("pb3", 0, 16, 32'b0101_0001_0100_0101, 32'b1111_0011_1100_1111,
              1'b0, 1'b0);
    idle(4);

    // Back-to-back pattern A twice, no bubble; detector fires twice.
    hits_base = hits1;
    sel = 2'b00; rep = 4'd2;
    run_frame("b2b", 1, 8, 32'b1011_1011, 32'b1111_1111, 1'b0, 1'b0);
    idle(4);
    chk("b2b_hits", 8'(hits1 - hits_base), 8'd2);

    // Custom word, its inverse, and rep=0 treated as one frame.
    sel = 2'b10; word = 4'b1100; rep = 4'd1;
    run_frame("word", 0, 4, 32'b1100, 32'b1111, 1'b0, 1'b0);
    idle(2);
    sel = 2'b11; word = 4'b1100; rep = 4'd1;
    run_frame("nword", 0, 4, 32'b0011, 32'b1111, 1'b0, 1'b0);
    idle(2);
    sel = 2'b00; rep = 4'd0;
    run_frame("rep0", 0, 4, 32'b1011, 32'b1111, 1'b0, 1'b0);
    idle(2);

    // start and inputs disturbed while busy, start held in DONE (ignored),
    // still high in the following IDLE cycle (accepted).
    sel = 2'b00; word = 4'b0000; rep = 4'd1;
    run_frame("ignore", 0, 4, 32'b1011, 32'b1111, 1'b1, 1'b1);
    run_frame("reacc", 0, 4, 32'b1011, 32'b1111, 1'b0, 1'b0);
    idle(2);

    // Asynchronous reset between edges during bit 2.
    sel = 2'b00; rep = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("rst_mid_pre", {7'd0, data_o[0]}, 8'd0);
    chk("rst_mid_prev", {7'd0, valid_o[0]}, 8'd1);
    #2;
    rs = 1'b0;
    #1;
    chk("rst_mid_data",  {7'd0, data_o[0]},  8'd0);
    chk("rst_mid_busy",  {7'd0, busy_o[0]},  8'd0);
    chk("rst_mid_valid", {7'd0, valid_o[0]}, 8'd0);
    chk("rst_mid_c",     {5'd0, c_o[0]},     8'd0);
    step();
    chk("rst_mid_done", {7'd0, done_o[0]}, 8'd0);
    rs = 1'b1;
    idle(1);
    chk("rst_mid_done2", {7'd0, done_o[0]}, 8'd0);
    sel = 2'b01; rep = 4'd1;
    run_frame("post_rst", 0, 4, 32'b0101, 32'b1111, 1'b0, 1'b0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
